// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between the fetch (IF) and load/store (DM) ports.
// DM has priority; a saturating starvation counter forces an IF grant after STARVE_MAX DM grants.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1,
   parameter int STARVE_MAX  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int LAT_W = $clog2(MEM_LATENCY + 1) + 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1) + 1;
   localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LATENCY);
   localparam logic [LAT_W-1:0] LAT_ONE   = {{(LAT_W-1){1'b0}}, 1'b1};
   localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_MAX);
   localparam logic [STV_W-1:0] STV_ONE   = {{(STV_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic               grant_dm_s;
   logic               grant_if_s;
   logic               lat_done_s;
   logic [LAT_W-1:0]   lat_cnt_r;
   logic [STV_W-1:0]   starve_cnt_r;
   logic               win_dm_r;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and arbitration; the winner is chosen only while idle
   always_comb begin
      state_nxt_s = state_r;
      grant_dm_s  = 1'b0;
      grant_if_s  = 1'b0;
      lat_done_s  = (lat_cnt_r == LAT_LAST);
      case (state_r)
         ST_IDLE: begin
            if (dm_req && !(if_req && (starve_cnt_r == STV_LIMIT))) begin
               grant_dm_s  = 1'b1;
               state_nxt_s = ST_ISSUE;
            end else if (if_req) begin
               grant_if_s  = 1'b1;
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: state_nxt_s = ST_WAIT;
         ST_WAIT: begin
            if (lat_done_s) begin
               state_nxt_s = ST_ACK;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_ACK:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Latency counter and starvation counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_cnt_r    <= '0;
         starve_cnt_r <= '0;
      end else begin
         if (state_r == ST_ISSUE) begin
            lat_cnt_r <= LAT_ONE;
         end else if (state_r == ST_WAIT) begin
            lat_cnt_r <= lat_cnt_r + LAT_ONE;
         end else begin
            lat_cnt_r <= lat_cnt_r;
         end
         if (grant_if_s) begin
            starve_cnt_r <= '0;
         end else if (grant_dm_s && if_req) begin
            starve_cnt_r <= (starve_cnt_r == STV_LIMIT) ? starve_cnt_r : starve_cnt_r + STV_ONE;
         end else if (grant_dm_s) begin
            starve_cnt_r <= '0;
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end
   end

   // Operands are latched at grant and held until the next grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         win_dm_r  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         mem_en <= grant_dm_s | grant_if_s;
         busy   <= (state_nxt_s != ST_IDLE);
         if (grant_dm_s) begin
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_we    <= dm_we;
            win_dm_r  <= 1'b1;
         end else if (grant_if_s) begin
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            win_dm_r  <= 1'b0;
         end else begin
            mem_addr  <= mem_addr;
            mem_wdata <= mem_wdata;
            mem_we    <= mem_we;
            win_dm_r  <= win_dm_r;
         end
      end
   end

   // Read data capture on the last wait cycle, followed by the winner's ack pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_ack   <= 1'b0;
         dm_ack   <= 1'b0;
         if_rdata <= '0;
         dm_rdata <= '0;
      end else if ((state_r == ST_WAIT) && lat_done_s) begin
         if_ack <= !win_dm_r;
         dm_ack <= win_dm_r;
         if (win_dm_r && !mem_we) begin
            dm_rdata <= mem_rdata;
         end else begin
            dm_rdata <= dm_rdata;
         end
         if (!win_dm_r) begin
            if_rdata <= mem_rdata;
         end else begin
            if_rdata <= if_rdata;
         end
      end else begin
         if_ack <= 1'b0;
         dm_ack <= 1'b0;
      end
   end

endmodule
